// File: rtl/diagnostics_pkg.sv
// Shared definitions for the diagnostics SPI readout block.
//
// Contents:
//   state_t         - sequencer states (IDLE, CMD, LOAD, STREAM)
//   DIAG_NUM_BYTES  - size of the diagnostics snapshot memory in bytes
//   *_HI / *_B3     - byte offsets of the fields inside the snapshot memory,
//                     usable as command bytes to start a read at that field
package diagnostics_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        LOAD   = 2'd2,
        STREAM = 2'd3
    } state_t;

    localparam int DIAG_NUM_BYTES = 16;

    localparam int ENC_COUNT_HI     = 0;
    localparam int TIME_PER_TICK_B3 = 2;
    localparam int RAW_VEL_HI       = 6;
    localparam int FILT_VEL_HI      = 8;
    localparam int GAIN_HI          = 10;
    localparam int TORQUE_HI        = 12;
    localparam int ELEC_ANGLE_HI    = 14;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-stage synchronizer with rise/fall detection for one SPI pin.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-high reset; preloads RESET_VALUE
//   din    in   asynchronous pin input
//   level  out  synchronized pin level (last synchronizer stage)
//   rise   out  one-cycle pulse on a synchronized 0->1 transition
//   fall   out  one-cycle pulse on a synchronized 1->0 transition
module spi_input_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   delayed;

    // Shifting through a vector keeps the chain valid for any depth >= 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain   <= {SYNC_STAGES{RESET_VALUE}};
            delayed <= RESET_VALUE;
        end else begin
            chain   <= (chain << 1) | SYNC_STAGES'(din);
            delayed <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~delayed;
    assign fall  = ~level & delayed;

endmodule

// File: rtl/diagnostics_spi_readout.sv
// SPI-slave (mode 0) sequencer for the diagnostics snapshot memory.
// A frame is: cs_n low, one command byte giving the start address, then any
// number of data bytes streamed from consecutive (wrapping) addresses.
// The memory is frozen for the whole frame so all bytes share one snapshot.
//
// Ports:
//   clk          in   system clock; SPI pins are oversampled on it
//   reset        in   asynchronous active-high reset
//   sck          in   SPI clock from host
//   cs_n         in   SPI chip select, active low
//   mosi         in   host -> block data, MSB first
//   miso         out  block -> host data, MSB first
//   freeze_data  out  holds the memory contents while high
//   mem_address  out  byte address into the diagnostics memory
//   mem_data     in   combinational read data at mem_address
//   busy         out  high whenever a frame is in progress
//   frame_count  out  count of frames that delivered at least one full byte
module diagnostics_spi_readout
    import diagnostics_pkg::*;
#(
    parameter int NUM_BYTES   = DIAG_NUM_BYTES,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sck,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        freeze_data,
    output logic [7:0]  mem_address,
    input  logic [7:0]  mem_data,
    output logic        busy,
    output logic [15:0] frame_count
);

    localparam logic [7:0] LAST_ADDR   = 8'(NUM_BYTES - 1);
    localparam logic [3:0] FLUSH_LIMIT = 4'(SYNC_STAGES + 1);

    logic sck_level, sck_rise, sck_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise, mosi_fall;

    logic unused_sync_outputs;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sck (
        .clk   (clk),
        .reset (reset),
        .din   (sck),
        .level (sck_level),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_cs (
        .clk   (clk),
        .reset (reset),
        .din   (cs_n),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_mosi (
        .clk   (clk),
        .reset (reset),
        .din   (mosi),
        .level (mosi_level),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    assign unused_sync_outputs = ^{sck_level, mosi_rise, mosi_fall};

    state_t      state, state_next;
    logic [7:0]  cmd_sr, cmd_next;
    logic [7:0]  tx_sr, tx_next;
    logic [3:0]  bit_cnt, bit_cnt_next;
    logic [7:0]  addr_next;
    logic [15:0] frames_next;
    logic        byte_done, byte_done_next;
    logic [7:0]  rx_byte;
    logic [3:0]  flush_cnt;
    logic        armed;

    // The cs_n synchronizer is preset high, so if the pin is held low through
    // reset a spurious synced fall appears once the chain flushes. A new frame
    // is only accepted after cs_n has been seen high with real (post-flush)
    // data, so a frame interrupted by reset is never resumed mid-way.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_cnt <= '0;
            armed     <= 1'b0;
        end else begin
            if (flush_cnt != FLUSH_LIMIT) begin
                flush_cnt <= flush_cnt + 4'd1;
            end
            if (flush_cnt == FLUSH_LIMIT && cs_level) begin
                armed <= 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cmd_sr      <= '0;
            tx_sr       <= '0;
            bit_cnt     <= '0;
            mem_address <= '0;
            frame_count <= '0;
            byte_done   <= 1'b0;
        end else begin
            state       <= state_next;
            cmd_sr      <= cmd_next;
            tx_sr       <= tx_next;
            bit_cnt     <= bit_cnt_next;
            mem_address <= addr_next;
            frame_count <= frames_next;
            byte_done   <= byte_done_next;
        end
    end

    // Next-state logic. A cs_n rise overrides any sck edge in the same cycle.
    // In STREAM, the fall right after a byte's 8th rise (bit_cnt == 0) is
    // skipped so the freshly loaded MSB stays on miso until the host samples it.
    always_comb begin
        state_next     = state;
        cmd_next       = cmd_sr;
        tx_next        = tx_sr;
        bit_cnt_next   = bit_cnt;
        addr_next      = mem_address;
        frames_next    = frame_count;
        byte_done_next = byte_done;
        rx_byte        = {cmd_sr[6:0], mosi_level};

        if (state != IDLE && cs_rise) begin
            state_next = IDLE;
            if (byte_done) begin
                frames_next = frame_count + 16'd1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall && armed) begin
                        state_next     = CMD;
                        cmd_next       = '0;
                        bit_cnt_next   = '0;
                        byte_done_next = 1'b0;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        cmd_next     = rx_byte;
                        bit_cnt_next = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            addr_next  = (rx_byte <= LAST_ADDR) ? rx_byte : 8'd0;
                            state_next = LOAD;
                        end
                    end
                end
                LOAD: begin
                    tx_next      = mem_data;
                    bit_cnt_next = '0;
                    state_next   = STREAM;
                end
                STREAM: begin
                    if (sck_fall && bit_cnt != 4'd0 && bit_cnt <= 4'd7) begin
                        tx_next = {tx_sr[6:0], 1'b0};
                    end
                    if (sck_rise) begin
                        bit_cnt_next = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            byte_done_next = 1'b1;
                            addr_next      = (mem_address == LAST_ADDR) ? 8'd0
                                                                        : mem_address + 8'd1;
                            state_next     = LOAD;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign freeze_data = (state != IDLE);
    assign miso        = (state == STREAM) ? tx_sr[7] : 1'b0;

endmodule
